alu_mul_sequencer: RTL and testbench

- Multi-cycle controller that computes RV64 MUL (low 64 bits of the product) by sequencing the shared 64-bit ALU through shift-and-add iterations.
- Sits beside the ALU in the sequential core and owns the ALU operand/control lines while busy.
- Upstream uses a valid/ready request handshake; downstream uses a valid/ready response handshake.

---
 rtl/alu_mul_sequencer.sv | 118 +++++++++++
 tb/tb_alu_mul_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle RV64 MUL sequencer: drives the shared ALU through
// shift-and-add iterations and returns the low WIDTH product bits.
module alu_mul_sequencer #(
    parameter int WIDTH      = 64,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] acc, acc_nx;
    logic [WIDTH-1:0] mcand, mcand_nx;
    logic [WIDTH-1:0] mplier, mplier_nx;
    logic [CW-1:0]    count, count_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else begin
            state  <= state_nx;
            acc    <= acc_nx;
            mcand  <= mcand_nx;
            mplier <= mplier_nx;
            count  <= count_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        acc_nx      = acc;
        mcand_nx    = mcand;
        mplier_nx   = mplier;
        count_nx    = count;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_result = '0;
        busy        = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_ctrl    = 2'b00;

        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    acc_nx    = '0;
                    mcand_nx  = req_a;
                    mplier_nx = req_b;
                    count_nx  = '0;
                    if (EARLY_EXIT && (req_b == '0))
                        state_nx = DONE;
                    else
                        state_nx = BUSY;
                end
            end
            BUSY: begin
                busy  = 1'b1;
                alu_a = acc;
                alu_b = mcand;
                if (mplier[0])
                    acc_nx = alu_result;
                mcand_nx  = mcand << 1;
                mplier_nx = mplier >> 1;
                count_nx  = count + CW'(1);
                // Stop early once no set multiplier bits remain.
                if ((count == LAST) ||
                    (EARLY_EXIT && ((mplier >> 1) == '0)))
                    state_nx = DONE;
            end
            DONE: begin
                resp_valid  = 1'b1;
                resp_result = acc;
                if (resp_ready)
                    state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (flush) begin
            state_nx  = IDLE;
            acc_nx    = '0;
            mcand_nx  = '0;
            mplier_nx = '0;
            count_nx  = '0;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed and randomized checks of alu_mul_sequencer with a
// behavioural ALU, for both EARLY_EXIT settings.
module tb_alu_mul_sequencer;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, resp_valid, resp_ready;
    logic        flush, busy;
    logic [63:0] req_a, req_b, resp_result;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [1:0]  alu_ctrl;

    logic        z_req_valid, z_req_ready, z_resp_valid, z_resp_ready;
    logic        z_flush, z_busy;
    logic [63:0] z_req_a, z_req_b, z_resp_result;
    logic [63:0] z_alu_a, z_alu_b, z_alu_result;
    logic [1:0]  z_alu_ctrl;

    int checks = 0;
    int errors = 0;

    alu_mul_sequencer #(.WIDTH(64), .EARLY_EXIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .flush(flush), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result)
    );

    alu_mul_sequencer #(.WIDTH(64), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_a(z_req_a), .req_b(z_req_b),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_result(z_resp_result), .flush(z_flush), .busy(z_busy),
        .alu_a(z_alu_a), .alu_b(z_alu_b), .alu_ctrl(z_alu_ctrl),
        .alu_result(z_alu_result)
    );

    function automatic logic [63:0] alu_f(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [1:0] c);
        case (c)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a | b;
            default: return a & b;
        endcase
    endfunction

    always_comb alu_result   = alu_f(alu_a, alu_b, alu_ctrl);
    always_comb z_alu_result = alu_f(z_alu_a, z_alu_b, z_alu_ctrl);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_n(input logic [63:0] b);
        int n = 0;
        for (int i = 0; i < 64; i++)
            if (b[i]) n = i + 1;
        return n;
    endfunction

    // Runs one transaction on dut; caller is at a negedge with dut IDLE.
    task automatic do_mul(input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int n,
                          output int bcyc, output bit ctrl_bad,
                          output bit rdy_bad, output bit to);
        res = '0; n = 0; bcyc = 0;
        ctrl_bad = 0; rdy_bad = 0; to = 0;
        req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        req_a = ~a; req_b = ~b;
        while (!resp_valid && n < 200) begin
            if (busy) bcyc++;
            if (busy && alu_ctrl !== 2'b00) ctrl_bad = 1;
            if (req_ready) rdy_bad = 1;
            @(posedge clk); @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            to = 1;
        end else begin
            if (req_ready) rdy_bad = 1;
            res = resp_result;
            resp_ready = 1'b1;
            @(posedge clk); @(negedge clk);
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready got %b exp 1", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid_busy got %b%b exp 00",
                     resp_valid, busy);
        end
        checks++;
        if (resp_result !== 64'd0 || alu_a !== 64'd0 ||
            alu_b !== 64'd0 || alu_ctrl !== 2'b00) begin
            errors++;
            $display("FAIL reset_data got r=%h a=%h b=%h c=%b exp zeros",
                     resp_result, alu_a, alu_b, alu_ctrl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [63:0] r; int n, bc; bit cb, rb, to;
        do_mul(64'd3, 64'd5, r, n, bc, cb, rb, to);
        checks++;
        if (to || r !== 64'd15) begin
            errors++;
            $display("FAIL basic_result got %0d exp 15 (to=%0d)", r, to);
        end
        checks++;
        if (n !== 3 || bc !== 3) begin
            errors++;
            $display("FAIL basic_latency got n=%0d busy=%0d exp 3/3", n, bc);
        end
        checks++;
        if (cb || rb) begin
            errors++;
            $display("FAIL basic_ctrl got ctrl_bad=%0d rdy_bad=%0d exp 0/0",
                     cb, rb);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] r; int n, bc; bit cb, rb, to;
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, n, bc, cb, rb, to);
        checks++;
        if (to || r !== 64'hFFFF_FFFF_FFFF_FFFE || n !== 2) begin
            errors++;
            $display("FAIL wrap_ones got %h n=%0d exp fffffffffffffffe n=2",
                     r, n);
        end
        do_mul(64'd3, 64'h8000_0000_0000_0000, r, n, bc, cb, rb, to);
        checks++;
        if (to || r !== 64'h8000_0000_0000_0000 || n !== 64) begin
            errors++;
            $display("FAIL wrap_msb got %h n=%0d exp 8000000000000000 n=64",
                     r, n);
        end
        do_mul(-64'sd3, 64'd4, r, n, bc, cb, rb, to);
        checks++;
        if (to || r !== 64'hFFFF_FFFF_FFFF_FFF4 || n !== 3) begin
            errors++;
            $display("FAIL neg_mul got %h n=%0d exp fffffffffffffff4 n=3",
                     r, n);
        end
    endtask

    task automatic test_zero();
        logic [63:0] r; int n, bc; bit cb, rb, to;
        do_mul(64'd123, 64'd0, r, n, bc, cb, rb, to);
        checks++;
        if (to || r !== 64'd0 || n !== 0 || bc !== 0) begin
            errors++;
            $display("FAIL zero_mul got r=%0d n=%0d busy=%0d exp 0/0/0",
                     r, n, bc);
        end
    endtask

    task automatic test_no_early();
        int bc = 0;
        int n = 0;
        logic [63:0] r = '0;
        z_req_a = 64'd7; z_req_b = 64'd1; z_req_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        z_req_valid = 1'b0;
        while (!z_resp_valid && n < 200) begin
            if (z_busy) bc++;
            @(posedge clk); @(negedge clk);
            n++;
        end
        if (z_resp_valid) r = z_resp_result;
        checks++;
        if (!z_resp_valid || r !== 64'd7 || bc !== 64) begin
            errors++;
            $display("FAIL no_early got r=%0d busy=%0d v=%b exp 7/64/1",
                     r, bc, z_resp_valid);
        end
        z_resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        z_resp_ready = 1'b0;
    endtask

    task automatic test_stall();
        int n = 0;
        bit bad = 0;
        req_a = 64'd6; req_b = 64'd7; req_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        req_a = 64'd2; req_b = 64'd3;
        while (!resp_valid && n < 200) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            if (resp_valid !== 1'b1 || resp_result !== 64'd42 ||
                req_ready !== 1'b0)
                bad = 1;
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (bad || resp_result !== 64'd42) begin
            errors++;
            $display("FAIL stall_hold got r=%0d v=%b rdy=%b exp 42/1/0",
                     resp_result, resp_valid, req_ready);
        end
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got v=%b rdy=%b busy=%b exp 0/1/0",
                     resp_valid, req_ready, busy);
        end
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_next_accept got busy=%b exp 1", busy);
        end
        n = 0;
        while (!resp_valid && n < 200) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_result !== 64'd6) begin
            errors++;
            $display("FAIL stall_second got r=%0d v=%b exp 6/1",
                     resp_result, resp_valid);
        end
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_flush();
        bit seen = 0;
        req_a = 64'd9; req_b = 64'hFF; req_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (alu_a !== 64'd0 || alu_b !== 64'd9 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_iter1 got a=%0d b=%0d busy=%b exp 0/9/1",
                     alu_a, alu_b, busy);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (alu_a !== 64'd9 || alu_b !== 64'd18) begin
            errors++;
            $display("FAIL flush_iter2 got a=%0d b=%0d exp 9/18",
                     alu_a, alu_b);
        end
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || alu_a !== 64'd0) begin
            errors++;
            $display("FAIL flush_busy got busy=%b rdy=%b a=%0d exp 0/1/0",
                     busy, req_ready, alu_a);
        end
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) seen = 1;
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_no_resp got resp_valid seen=1 exp 0");
        end
        req_a = 64'd4; req_b = 64'd4; req_valid = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_req_ready got %b exp 1", req_ready);
        end
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_accept got busy=%b v=%b exp 0/0",
                     busy, resp_valid);
        end
        req_a = 64'd5; req_b = 64'd0; req_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done got v=%b rdy=%b exp 0/1",
                     resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        req_a = 64'd9; req_b = 64'hFF; req_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 ||
            alu_a !== 64'd0 || alu_b !== 64'd0 || resp_result !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b rdy=%b v=%b a=%h b=%h",
                     busy, req_ready, resp_valid, alu_a, alu_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid || busy) seen = 1;
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_quiet got activity=1 exp 0");
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b, r; int n, bc; bit cb, rb, to;
        for (int i = 0; i < 200; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            if (i == 0) begin a = -64'sd3; b = 64'd4; end
            if (i == 1) begin a = 64'd4;   b = -64'sd3; end
            if (i % 25 == 7) b = '0;
            do_mul(a, b, r, n, bc, cb, rb, to);
            checks++;
            if (to || r !== a * b) begin
                errors++;
                $display("FAIL b2b_result[%0d] got %h exp %h", i, r, a * b);
            end
            checks++;
            if (n !== ref_n(b) || bc !== ref_n(b) || cb || rb) begin
                errors++;
                $display("FAIL b2b_cycles[%0d] got n=%0d busy=%0d exp %0d",
                         i, n, bc, ref_n(b));
            end
        end
    endtask

    initial begin
        req_valid = 0; req_a = 0; req_b = 0; resp_ready = 0; flush = 0;
        z_req_valid = 0; z_req_a = 0; z_req_b = 0;
        z_resp_ready = 0; z_flush = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_no_early();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
